// File: rtl/imm_ext_stage.sv
// imm_ext_stage: immediate extender (sign/zero/upper/branch) behind a 2-entry valid/ready FIFO.
// The head item is mirrored in a dedicated output register so out_data holds while empty.
module imm_ext_stage #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic [1:0]       occupancy
);
    localparam int E_W = OUT_W + TAG_W;

    logic [E_W-1:0]   mem_q [2];
    logic [E_W-1:0]   out_q, out_d, new_entry;
    logic [1:0]       count_q, count_d;
    logic             head_q, head_d, tail_q, tail_d;
    logic             acc, pop;
    logic [OUT_W-1:0] sign_ext, ext;

    assign sign_ext  = {{(OUT_W-IN_W){in_imm[IN_W-1]}}, in_imm};
    assign in_ready  = count_q != 2'd2;
    assign out_valid = count_q != 2'd0;
    assign occupancy = count_q;
    assign {out_tag, out_data} = out_q;

    always_comb begin
        ext = in_mode == 2'b00 ? sign_ext :
              in_mode == 2'b01 ? OUT_W'(in_imm) :
              in_mode == 2'b10 ? OUT_W'(in_imm) << IN_W :
                                 sign_ext << 2;
        new_entry = {in_tag, ext};
        acc = in_valid && in_ready && !flush;
        pop = out_valid && out_ready && !flush;
        count_d = flush ? 2'd0 : count_q + 2'(acc) - 2'(pop);
        head_d = flush ? 1'b0 : head_q ^ pop;
        tail_d = flush ? 1'b0 : tail_q ^ acc;
        // The new item becomes head when the FIFO is empty or its only entry leaves now
        out_d = (acc && (count_q == 2'd0 || pop)) ? new_entry :
                (pop && count_q == 2'd2)          ? mem_q[~head_q] : out_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            out_q   <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            out_q   <= out_d;
        end
    end

    always_ff @(posedge clk) begin
        if (acc) mem_q[tail_q] <= new_entry;
    end
endmodule

// File: tb/tb_imm_ext_stage.sv
// tb_imm_ext_stage: directed self-checking bench for imm_ext_stage (IN_W=16, OUT_W=32, TAG_W=5).
module tb_imm_ext_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_imm = '0;
    logic [1:0]  in_mode = '0;
    logic [4:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [4:0]  out_tag;
    logic [1:0]  occupancy;
    int          checks = 0;
    int          failures = 0;

    imm_ext_stage #(.IN_W(16), .OUT_W(32), .TAG_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm),
        .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] imm, input logic [1:0] mode, input logic [4:0] tag);
        in_valid = 1'b1;
        in_imm   = imm;
        in_mode  = mode;
        in_tag   = tag;
    endtask

    initial begin
        #12 rst_n = 1'b1;
        cyc();
        chk("rst_occ", occupancy, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_tag", out_tag, 0);

        // modes + streaming: tags 1..4 back to back
        out_ready = 1'b1;
        push(16'h8001, 2'b00, 5'd1);
        cyc();
        chk("sign_valid", out_valid, 1);
        chk("sign_data", out_data, 32'hFFFF8001);
        chk("sign_tag", out_tag, 1);
        push(16'h8001, 2'b01, 5'd2);
        cyc();
        chk("zero_data", out_data, 32'h00008001);
        chk("zero_tag", out_tag, 2);
        push(16'h8001, 2'b10, 5'd3);
        cyc();
        chk("upper_data", out_data, 32'h80010000);
        chk("upper_tag", out_tag, 3);
        chk("stream_occ", occupancy, 1);
        push(16'h8001, 2'b11, 5'd4);
        cyc();
        chk("branch_data", out_data, 32'hFFFE0004);
        chk("branch_tag", out_tag, 4);
        in_valid = 1'b0;
        cyc();
        chk("drain_valid", out_valid, 0);
        chk("drain_occ", occupancy, 0);
        chk("hold_data", out_data, 32'hFFFE0004);

        // backpressure
        out_ready = 1'b0;
        push(16'h0011, 2'b01, 5'd5);
        cyc();
        chk("bp1_occ", occupancy, 1);
        chk("bp1_data", out_data, 32'h11);
        chk("bp1_in_ready", in_ready, 1);
        push(16'h0022, 2'b01, 5'd6);
        cyc();
        chk("bp2_occ", occupancy, 2);
        chk("bp2_in_ready", in_ready, 0);
        chk("bp2_data", out_data, 32'h11);
        push(16'h0033, 2'b01, 5'd7);
        cyc();
        chk("bp3_occ", occupancy, 2);
        chk("bp3_data", out_data, 32'h11);
        chk("bp3_tag", out_tag, 5);
        out_ready = 1'b1;
        cyc();
        chk("bp4_occ", occupancy, 1);
        chk("bp4_tag", out_tag, 6);
        chk("bp4_data", out_data, 32'h22);
        cyc();
        chk("bp5_occ", occupancy, 1);
        chk("bp5_tag", out_tag, 7);
        chk("bp5_data", out_data, 32'h33);
        in_valid = 1'b0;
        cyc();
        chk("bp6_occ", occupancy, 0);
        chk("bp6_valid", out_valid, 0);

        // pop on empty, then simultaneous push/pop at count 1
        cyc();
        chk("empty_pop_occ", occupancy, 0);
        chk("empty_pop_data", out_data, 32'h33);
        out_ready = 1'b0;
        push(16'h7FFF, 2'b00, 5'd8);
        cyc();
        chk("pp1_occ", occupancy, 1);
        chk("pp1_data", out_data, 32'h00007FFF);
        out_ready = 1'b1;
        push(16'h0001, 2'b11, 5'd9);
        cyc();
        chk("pp2_occ", occupancy, 1);
        chk("pp2_tag", out_tag, 9);
        chk("pp2_data", out_data, 32'h4);
        in_valid = 1'b0;
        cyc();
        chk("pp3_occ", occupancy, 0);

        // flush with count 2 and a same-cycle in_valid
        out_ready = 1'b0;
        push(16'hFFFF, 2'b10, 5'd10);
        cyc();
        push(16'h0002, 2'b01, 5'd11);
        cyc();
        chk("fl_pre_occ", occupancy, 2);
        chk("fl_pre_data", out_data, 32'hFFFF0000);
        push(16'h0003, 2'b01, 5'd12);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_occ", occupancy, 0);
        chk("fl_valid", out_valid, 0);
        chk("fl_in_ready", in_ready, 1);
        out_ready = 1'b1;
        cyc();
        chk("fl_dropped_valid", out_valid, 0);
        chk("fl_hold_data", out_data, 32'hFFFF0000);

        // async reset mid-stream with count 2
        out_ready = 1'b0;
        push(16'h0044, 2'b01, 5'd13);
        cyc();
        push(16'h0055, 2'b01, 5'd14);
        cyc();
        in_valid = 1'b0;
        chk("ar_pre_occ", occupancy, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_occ", occupancy, 0);
        chk("ar_valid", out_valid, 0);
        chk("ar_data", out_data, 0);
        #3 rst_n = 1'b1;
        cyc();
        chk("ar_in_ready", in_ready, 1);
        chk("ar_post_occ", occupancy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
